// File: rtl/multdiv_seq_if.sv
// Request/result bundle between the writeback stage and the multiply/divide
// sequencer. The master issues operations; the slave is the sequencer.
interface multdiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT,
        output ctrl_DIV,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_exception,
        input  data_resultRDY,
        input  busy
    );

    modport slave (
        input  ctrl_MULT,
        input  ctrl_DIV,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_exception,
        output data_resultRDY,
        output busy
    );
endinterface

// File: rtl/multdiv_seq.sv
// Iterative signed multiply/divide sequencer.
// One Booth (multiply) or restoring (divide) iteration per clock, stepped by an
// external counter whose enable and clear this block drives, followed by one
// sign/overflow fix-up cycle and a single-cycle result-valid pulse.
//
// state | meaning
// IDLE  | waiting for ctrl_MULT / ctrl_DIV
// RUN   | one iteration per edge; leaves after the edge where count == WIDTH-1
// FIX   | sign correction and overflow/div-by-zero detection, result registered
// DONE  | data_resultRDY high for exactly this cycle
module multdiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [CNT_W-1:0] count,
    output logic             cnt_en,
    output logic             cnt_clr,
    multdiv_seq_if.slave     bus
);

    localparam int ACC_W = 2 * WIDTH + 1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic             start;
    logic             op_mult;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    // Multiply: {P, A, q-1}.  Divide: {remainder[WIDTH:0], quotient[WIDTH-1:0]}.
    logic [ACC_W-1:0] acc;
    logic [WIDTH-1:0] result_q;
    logic             exception_q;

    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   booth_p;
    logic [WIDTH:0]   booth_m;
    logic [WIDTH:0]   booth_sum;
    logic [ACC_W-1:0] booth_nxt;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [ACC_W-1:0] div_nxt;
    logic [WIDTH-1:0] fix_result;
    logic             fix_exc;
    logic [WIDTH-1:0] quot;
    logic [WIDTH:0]   prod_hi;

    assign start   = bus.ctrl_MULT | bus.ctrl_DIV;
    assign cnt_clr = start & clr;
    assign cnt_en  = (state == RUN);

    assign bus.busy           = (state == RUN) || (state == FIX);
    assign bus.data_resultRDY = (state == DONE);
    assign bus.data_result    = result_q;
    assign bus.data_exception = exception_q;

    // Operand magnitudes for the divide; the most negative value maps onto
    // itself, which is the correct unsigned magnitude.
    always_comb begin
        mag_a_in = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + ONE) : bus.data_operandA;
        mag_b    = b_reg[WIDTH-1] ? (~b_reg + ONE) : b_reg;
    end

    // Radix-2 Booth step. P is widened by one bit so that subtracting the most
    // negative multiplicand cannot overflow before the arithmetic shift.
    always_comb begin
        booth_p = {acc[ACC_W-1], acc[ACC_W-1 -: WIDTH]};
        booth_m = {a_reg[WIDTH-1], a_reg};
        case (acc[1:0])
            2'b01:   booth_sum = booth_p + booth_m;
            2'b10:   booth_sum = booth_p - booth_m;
            default: booth_sum = booth_p;
        endcase
        booth_nxt = {booth_sum, acc[WIDTH:1]};
    end

    // Restoring divide step on magnitudes: shift in the next dividend bit, try
    // the subtraction, keep it only if the partial remainder stays non-negative.
    always_comb begin
        div_shift = {acc[ACC_W-2 -: WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        if (!div_diff[WIDTH]) begin
            div_nxt = {div_diff, acc[WIDTH-2:0], 1'b1};
        end else begin
            div_nxt = {div_shift, acc[WIDTH-2:0], 1'b0};
        end
    end

    // Fix-up: product truncation overflow, divide sign correction and the two
    // divide corner cases.
    always_comb begin
        fix_result = '0;
        fix_exc    = 1'b0;
        prod_hi    = acc[ACC_W-1:WIDTH];
        quot       = acc[WIDTH-1:0];
        if (op_mult) begin
            fix_result = acc[WIDTH:1];
            fix_exc    = !((&prod_hi) || !(|prod_hi));
        end else if (b_reg == '0) begin
            fix_result = '0;
            fix_exc    = 1'b1;
        end else if ((a_reg == MIN_NEG) && (&b_reg)) begin
            fix_result = MIN_NEG;
            fix_exc    = 1'b1;
        end else begin
            fix_result = (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) ? (~quot + ONE) : quot;
            fix_exc    = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; a start restarts from any state and suppresses the pending result.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RUN;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                RUN:     state_nxt = (count == LAST) ? FIX : RUN;
                FIX:     state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Operand capture and per-edge iteration of the accumulator.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            op_mult <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
        end else if (start) begin
            op_mult <= bus.ctrl_MULT;
            a_reg   <= bus.data_operandA;
            b_reg   <= bus.data_operandB;
            if (bus.ctrl_MULT) begin
                acc <= {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
            end else begin
                acc <= {{(WIDTH+1){1'b0}}, mag_a_in};
            end
        end else if (state == RUN) begin
            acc <= op_mult ? booth_nxt : div_nxt;
        end
    end

    // Result registers; they hold until the next completed fix-up.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            result_q    <= '0;
            exception_q <= 1'b0;
        end else if ((state == FIX) && !start) begin
            result_q    <= fix_result;
            exception_q <= fix_exc;
        end
    end

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq with a behavioural step counter attached.
module tb_multdiv_seq;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [5:0] count = 6'd0;
    logic       cnt_en;
    logic       cnt_clr;

    multdiv_seq_if #(.WIDTH(32)) bus ();

    multdiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk     (clk),
        .clr     (clr),
        .count   (count),
        .cnt_en  (cnt_en),
        .cnt_clr (cnt_clr),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // counter32 behaviour: clear wins over enable
    always @(posedge clk) begin
        if (cnt_clr) count <= 6'd0;
        else if (cnt_en) count <= count + 6'd1;
    end

    int   total = 0;
    int   bad = 0;
    int   lat, pulses, clr_hits, busy_bad;
    logic clr_at_start;

    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.ctrl_MULT = m;
        bus.ctrl_DIV = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        #1 clr_at_start = cnt_clr;
        @(posedge clk);
        #1;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = 32'hDEADBEEF;
        bus.data_operandB = 32'h12345678;
    endtask

    task automatic watch(input int n);
        lat = 0; pulses = 0; clr_hits = 0; busy_bad = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (bus.data_resultRDY === 1'b1) begin
                pulses++;
                if (lat == 0) lat = i;
            end
            if (cnt_clr !== 1'b0) clr_hits++;
            if (i <= 32 && bus.busy !== 1'b1) busy_bad++;
        end
    endtask

    task automatic test_reset();
        bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
        bus.data_operandA = 32'd0; bus.data_operandB = 32'd0;
        repeat (2) @(negedge clk);
        total++; if (bus.data_result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.data_result); end
        total++; if (bus.data_exception !== 1'b0) begin bad++; $display("FAIL reset_exc got=%b want=0", bus.data_exception); end
        total++; if (bus.data_resultRDY !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0", bus.data_resultRDY); end
        total++; if ({bus.busy, cnt_en} !== 2'b00) begin bad++; $display("FAIL reset_busy_en got=%b want=00", {bus.busy, cnt_en}); end
        bus.ctrl_MULT = 1'b1;
        #1;
        total++; if (cnt_clr !== 1'b0) begin bad++; $display("FAIL reset_cnt_clr_gated got=%b want=0", cnt_clr); end
        bus.ctrl_MULT = 1'b0;
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_mult();
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFA);
        watch(40);
        total++; if (clr_at_start !== 1'b1) begin bad++; $display("FAIL mult7x-6_clr_start got=%b want=1", clr_at_start); end
        total++; if (clr_hits != 0) begin bad++; $display("FAIL mult7x-6_clr_extra got=%0d want=0", clr_hits); end
        total++; if (lat != 33) begin bad++; $display("FAIL mult7x-6_latency got=%0d want=33", lat); end
        total++; if (pulses != 1) begin bad++; $display("FAIL mult7x-6_pulses got=%0d want=1", pulses); end
        total++; if (busy_bad != 0) begin bad++; $display("FAIL mult7x-6_busy got=%0d_low_cycles want=0", busy_bad); end
        total++; if (bus.data_result !== 32'hFFFFFFD6) begin bad++; $display("FAIL mult7x-6_result got=%h want=ffffffd6", bus.data_result); end
        total++; if (bus.data_exception !== 1'b0) begin bad++; $display("FAIL mult7x-6_exc got=%b want=0", bus.data_exception); end

        start_op(1'b1, 1'b0, 32'h00010000, 32'h00010000);
        watch(40);
        total++; if (bus.data_result !== 32'h0) begin bad++; $display("FAIL mult_ovf_result got=%h want=0", bus.data_result); end
        total++; if (bus.data_exception !== 1'b1) begin bad++; $display("FAIL mult_ovf_exc got=%b want=1", bus.data_exception); end

        start_op(1'b1, 1'b0, 32'h80000000, 32'd1);
        watch(40);
        total++; if (bus.data_result !== 32'h80000000) begin bad++; $display("FAIL mult_minx1_result got=%h want=80000000", bus.data_result); end
        total++; if (bus.data_exception !== 1'b0) begin bad++; $display("FAIL mult_minx1_exc got=%b want=0", bus.data_exception); end

        start_op(1'b1, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFFB);
        watch(40);
        total++; if ({bus.data_exception, bus.data_result} !== {1'b0, 32'd15}) begin bad++; $display("FAIL mult-3x-5 got=%b/%h want=0/0000000f", bus.data_exception, bus.data_result); end
    endtask

    task automatic test_reset_midrun();
        start_op(1'b1, 1'b0, 32'd5, 32'd5);
        watch(9);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL midrun_busy_before got=%b want=1", bus.busy); end
        @(negedge clk);
        clr = 1'b0;
        #1;
        total++; if (bus.data_result !== 32'd0) begin bad++; $display("FAIL midrun_result got=%h want=0", bus.data_result); end
        total++; if ({bus.data_exception, bus.data_resultRDY, bus.busy, cnt_en, cnt_clr} !== 5'b0)
            begin bad++; $display("FAIL midrun_flags got=%b want=00000", {bus.data_exception, bus.data_resultRDY, bus.busy, cnt_en, cnt_clr}); end
        @(negedge clk);
        clr = 1'b1;
        watch(40);
        total++; if (pulses != 0) begin bad++; $display("FAIL midrun_no_rdy got=%0d want=0", pulses); end
        total++; if (bus.data_result !== 32'd0) begin bad++; $display("FAIL midrun_hold got=%h want=0", bus.data_result); end
    endtask

    task automatic test_div();
        start_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
        watch(40);
        total++; if (lat != 33) begin bad++; $display("FAIL div-7/2_latency got=%0d want=33", lat); end
        total++; if ({bus.data_exception, bus.data_result} !== {1'b0, 32'hFFFFFFFD}) begin bad++; $display("FAIL div-7/2 got=%b/%h want=0/fffffffd", bus.data_exception, bus.data_result); end

        start_op(1'b0, 1'b1, 32'd100, 32'd0);
        watch(40);
        total++; if (lat != 33) begin bad++; $display("FAIL div100/0_latency got=%0d want=33", lat); end
        total++; if ({bus.data_exception, bus.data_result} !== {1'b1, 32'd0}) begin bad++; $display("FAIL div100/0 got=%b/%h want=1/00000000", bus.data_exception, bus.data_result); end

        start_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        watch(40);
        total++; if ({bus.data_exception, bus.data_result} !== {1'b1, 32'h80000000}) begin bad++; $display("FAIL divmin/-1 got=%b/%h want=1/80000000", bus.data_exception, bus.data_result); end

        start_op(1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9);
        watch(40);
        total++; if ({bus.data_exception, bus.data_result} !== {1'b0, 32'd14}) begin bad++; $display("FAIL div-100/-7 got=%b/%h want=0/0000000e", bus.data_exception, bus.data_result); end

        start_op(1'b0, 1'b1, 32'd7, 32'hFFFFFFFE);
        watch(40);
        total++; if ({bus.data_exception, bus.data_result} !== {1'b0, 32'hFFFFFFFD}) begin bad++; $display("FAIL div7/-2 got=%b/%h want=0/fffffffd", bus.data_exception, bus.data_result); end
    endtask

    task automatic test_restart();
        start_op(1'b0, 1'b1, 32'd9, 32'd3);
        watch(14);
        total++; if (pulses != 0) begin bad++; $display("FAIL restart_early_rdy got=%0d want=0", pulses); end
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        total++; if (clr_at_start !== 1'b1) begin bad++; $display("FAIL restart_cnt_clr got=%b want=1", clr_at_start); end
        watch(40);
        total++; if (pulses != 1) begin bad++; $display("FAIL restart_pulses got=%0d want=1", pulses); end
        total++; if (lat != 33) begin bad++; $display("FAIL restart_latency got=%0d want=33", lat); end
        total++; if ({bus.data_exception, bus.data_result} !== {1'b0, 32'd12}) begin bad++; $display("FAIL restart_result got=%b/%h want=0/0000000c", bus.data_exception, bus.data_result); end
    endtask

    task automatic test_simultaneous();
        start_op(1'b1, 1'b1, 32'd6, 32'd3);
        watch(40);
        total++; if (lat != 33) begin bad++; $display("FAIL both_latency got=%0d want=33", lat); end
        total++; if ({bus.data_exception, bus.data_result} !== {1'b0, 32'd18}) begin bad++; $display("FAIL both_result got=%b/%h want=0/00000012", bus.data_exception, bus.data_result); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_reset_midrun();
        test_div();
        test_restart();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
